// File: rtl/mem_line_requester_pkg.sv
// Shared definitions for the cache-line requester: memory message codes,
// requester state encoding and a constant log2 helper.
package mem_line_requester_pkg;

  // Message codes on the main-memory port.
  localparam int unsigned NO_REQ   = 0;
  localparam int unsigned R_REQ    = 1;
  localparam int unsigned WB_REQ   = 2;
  localparam int unsigned MEM_RESP = 3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQUEST,
    S_GAP,
    S_DONE
  } state_t;

  // Ceiling log2 usable in constant expressions.
  function automatic int unsigned f_log2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/mem_line_requester_timeout.sv
// Request watchdog: counts cycles spent waiting in one REQUEST state and
// flags expiry. Only built when MEM_REQ_TIMEOUT_EN is defined.
`ifdef MEM_REQ_TIMEOUT_EN
module req_timeout_counter
  import mem_line_requester_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic clock,
  input  logic reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int unsigned CW = f_log2(TIMEOUT_CYCLES);

  logic [CW-1:0] r_count;

  // Count enabled cycles since the last clear, saturating at expiry.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && !o_expired) begin
      r_count <= r_count + 1'b1;
    end
  end

  // Expiry is seen during the last allowed cycle so the abort lands on it.
  assign o_expired = (r_count == CW'(TIMEOUT_CYCLES - 1));

endmodule
`endif

// File: rtl/mem_line_requester.sv
// Cache-line requester: splits one line read/writeback into per-word
// R_REQ/WB_REQ transactions toward main memory and collects MEM_RESP.
// Optional feature macro: MEM_REQ_TIMEOUT_EN (REQUEST watchdog, error flag).
module mem_line_requester
  import mem_line_requester_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDRESS_WIDTH  = 32,
  parameter int MSG_BITS       = 4,
  parameter int WORDS_PER_LINE = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 req_valid,
  output logic                                 req_ready,
  input  logic                                 req_write,
  input  logic [ADDRESS_WIDTH-1:0]             req_address,
  input  logic [WORDS_PER_LINE*DATA_WIDTH-1:0] req_data,
  output logic                                 resp_valid,
  output logic [WORDS_PER_LINE*DATA_WIDTH-1:0] resp_data,
  output logic                                 error,
  output logic [MSG_BITS-1:0]                  mem_msg_out,
  output logic [ADDRESS_WIDTH-1:0]             mem_address_out,
  output logic [DATA_WIDTH-1:0]                mem_data_out,
  input  logic [MSG_BITS-1:0]                  mem_msg_in,
  input  logic [ADDRESS_WIDTH-1:0]             mem_address_in,
  input  logic [DATA_WIDTH-1:0]                mem_data_in
);

  localparam int unsigned CNT_W  = f_log2(WORDS_PER_LINE);
  localparam int          LINE_W = WORDS_PER_LINE * DATA_WIDTH;

  localparam logic [MSG_BITS-1:0]      C_NO_REQ   = MSG_BITS'(NO_REQ);
  localparam logic [MSG_BITS-1:0]      C_R_REQ    = MSG_BITS'(R_REQ);
  localparam logic [MSG_BITS-1:0]      C_WB_REQ   = MSG_BITS'(WB_REQ);
  localparam logic [MSG_BITS-1:0]      C_MEM_RESP = MSG_BITS'(MEM_RESP);
  localparam logic [ADDRESS_WIDTH-1:0] C_ALIGN    = ~ADDRESS_WIDTH'(WORDS_PER_LINE - 1);
  localparam logic [CNT_W-1:0]         C_LAST     = CNT_W'(WORDS_PER_LINE - 1);

  // Elaboration guards on the configuration.
  if ((WORDS_PER_LINE < 2) || ((WORDS_PER_LINE & (WORDS_PER_LINE - 1)) != 0)) begin : g_bad_wpl
    $error("WORDS_PER_LINE must be a power of two >= 2");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be >= 2");
  end

  state_t                   r_state, w_state;
  logic                     r_write, w_write;
  logic [ADDRESS_WIDTH-1:0] r_base, w_base;
  logic [LINE_W-1:0]        r_line, w_line;
  logic [CNT_W-1:0]         r_cnt, w_cnt, w_cnt_inc;
  logic [MSG_BITS-1:0]      r_msg, w_msg, w_req_msg;
  logic [ADDRESS_WIDTH-1:0] r_addr, w_addr;
  logic [DATA_WIDTH-1:0]    r_wdata, w_wdata;
  logic                     r_resp_valid, w_resp_valid;
  logic [LINE_W-1:0]        r_resp_data, w_resp_data;
  logic                     w_match, w_last;

  assign w_cnt_inc = r_cnt + 1'b1;
  assign w_match   = (mem_msg_in == C_MEM_RESP) && (mem_address_in == r_addr);
  assign w_last    = (r_cnt == C_LAST);
  assign w_req_msg = r_write ? C_WB_REQ : C_R_REQ;

`ifdef MEM_REQ_TIMEOUT_EN
  logic r_error, w_error, w_expired, w_to_clear, w_to_enable;

  // Restart the watchdog on every REQUEST entry (accept or end of GAP).
  assign w_to_clear  = ((r_state == S_IDLE) && req_valid) || (r_state == S_GAP);
  assign w_to_enable = (r_state == S_REQUEST);

  req_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clock    (clock),
    .reset    (reset),
    .i_clear  (w_to_clear),
    .i_enable (w_to_enable),
    .o_expired(w_expired)
  );

  // Abort flag, held from the timed-out DONE until the next accept.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_error <= 1'b0;
    else        r_error <= w_error;
  end

  assign error = r_error;
`else
  assign error = 1'b0;
`endif

  // Next-state and next-output logic; every memory-side output is registered.
  always_comb begin
    w_state      = r_state;
    w_write      = r_write;
    w_base       = r_base;
    w_line       = r_line;
    w_cnt        = r_cnt;
    w_msg        = r_msg;
    w_addr       = r_addr;
    w_wdata      = r_wdata;
    w_resp_valid = 1'b0;
    w_resp_data  = r_resp_data;
`ifdef MEM_REQ_TIMEOUT_EN
    w_error      = r_error;
`endif
    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          w_write     = req_write;
          w_base      = req_address & C_ALIGN;
          w_line      = req_data;
          w_cnt       = '0;
          w_msg       = req_write ? C_WB_REQ : C_R_REQ;
          w_addr      = req_address & C_ALIGN;
          w_wdata     = req_write ? req_data[DATA_WIDTH-1:0] : '0;
          w_resp_data = '0;
`ifdef MEM_REQ_TIMEOUT_EN
          w_error     = 1'b0;
`endif
          w_state     = S_REQUEST;
        end
      end
      S_REQUEST: begin
        if (w_match) begin
          if (!r_write) w_resp_data[r_cnt*DATA_WIDTH +: DATA_WIDTH] = mem_data_in;
          w_msg   = C_NO_REQ;
          w_wdata = '0;
          if (w_last) begin
            w_state      = S_DONE;
            w_resp_valid = 1'b1;
          end else begin
            w_state = S_GAP;
          end
        end
`ifdef MEM_REQ_TIMEOUT_EN
        else if (w_expired) begin
          w_msg        = C_NO_REQ;
          w_wdata      = '0;
          w_error      = 1'b1;
          w_resp_valid = 1'b1;
          w_state      = S_DONE;
        end
`endif
      end
      S_GAP: begin
        // Memory has seen NO_REQ for one cycle; issue the next word.
        w_cnt   = w_cnt_inc;
        w_msg   = w_req_msg;
        w_addr  = r_base + ADDRESS_WIDTH'(w_cnt_inc);
        w_wdata = r_write ? r_line[w_cnt_inc*DATA_WIDTH +: DATA_WIDTH] : '0;
        w_state = S_REQUEST;
      end
      S_DONE: begin
        w_state = S_IDLE;
      end
      default: begin
        w_state = S_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_write      <= 1'b0;
      r_base       <= '0;
      r_line       <= '0;
      r_cnt        <= '0;
      r_msg        <= C_NO_REQ;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_resp_valid <= 1'b0;
      r_resp_data  <= '0;
    end else begin
      r_state      <= w_state;
      r_write      <= w_write;
      r_base       <= w_base;
      r_line       <= w_line;
      r_cnt        <= w_cnt;
      r_msg        <= w_msg;
      r_addr       <= w_addr;
      r_wdata      <= w_wdata;
      r_resp_valid <= w_resp_valid;
      r_resp_data  <= w_resp_data;
    end
  end

  assign req_ready       = (r_state == S_IDLE);
  assign resp_valid      = r_resp_valid;
  assign resp_data       = r_resp_data;
  assign mem_msg_out     = r_msg;
  assign mem_address_out = r_addr;
  assign mem_data_out    = r_wdata;

endmodule

// File: tb/tb_mem_line_requester.sv
// Bench for mem_line_requester: single-port main-memory stub, transaction
// level reference memory, table vectors, hand sequences and random lines.
module tb_mem_line_requester;
  import mem_line_requester_pkg::*;

  localparam int DW  = 32;
  localparam int AW  = 32;
  localparam int MB  = 4;
  localparam int WPL = 4;
  localparam int LW  = WPL * DW;
  localparam int TO  = 8;
  localparam int RD_LAT = 4 * WPL - 1;
  localparam int WB_LAT = 3 * WPL - 1;

  localparam logic [MB-1:0] M_NO   = MB'(NO_REQ);
  localparam logic [MB-1:0] M_RD   = MB'(R_REQ);
  localparam logic [MB-1:0] M_WB   = MB'(WB_REQ);
  localparam logic [MB-1:0] M_RESP = MB'(MEM_RESP);

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_address = '0;
  logic [LW-1:0] req_data = '0;
  logic          resp_valid;
  logic [LW-1:0] resp_data;
  logic          error;
  logic [MB-1:0] mem_msg_out;
  logic [AW-1:0] mem_address_out;
  logic [DW-1:0] mem_data_out;
  logic [MB-1:0] mem_msg_in;
  logic [AW-1:0] mem_address_in;
  logic [DW-1:0] mem_data_in;

  always #5 clock = ~clock;

  mem_line_requester #(
    .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .MSG_BITS(MB),
    .WORDS_PER_LINE(WPL), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_address(req_address), .req_data(req_data),
    .resp_valid(resp_valid), .resp_data(resp_data), .error(error),
    .mem_msg_out(mem_msg_out), .mem_address_out(mem_address_out),
    .mem_data_out(mem_data_out), .mem_msg_in(mem_msg_in),
    .mem_address_in(mem_address_in), .mem_data_in(mem_data_in)
  );

  // ---------------- main-memory stub (single port, 256 words) -------------
  function automatic logic [31:0] init_word(input int i);
    if (i >= 64 && i < 72) return 32'hA000_0000 + 32'(i - 64);
    return 32'h5EED_0000 ^ (32'(i) * 32'h0000_9E37);
  endfunction

  logic [31:0]   smem [0:255];
  int            ms;
  logic [AW-1:0] rd_addr;
  logic [MB-1:0] st_msg;
  logic [AW-1:0] st_addr;
  logic [DW-1:0] st_data;
  logic          mute = 1'b0;
  logic          spur = 1'b0;

  assign mem_msg_in     = spur ? M_RESP : st_msg;
  assign mem_address_in = spur ? 32'hDEAD_BEEF : st_addr;
  assign mem_data_in    = st_data;

  // IDLE takes a request; reads reply one cycle later, writes immediately;
  // after replying the stub waits for NO_REQ before accepting again.
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      ms      <= 0;
      st_msg  <= M_NO;
      st_addr <= '0;
      st_data <= '0;
      rd_addr <= '0;
      for (int i = 0; i < 256; i++) smem[i] <= init_word(i);
    end else begin
      st_msg <= M_NO;
      case (ms)
        0: if (!mute) begin
          if (mem_msg_out == M_RD) begin
            rd_addr <= mem_address_out;
            ms      <= 1;
          end else if (mem_msg_out == M_WB) begin
            smem[mem_address_out[7:0]] <= mem_data_out;
            st_msg  <= M_RESP;
            st_addr <= mem_address_out;
            ms      <= 2;
          end
        end
        1: begin
          st_msg  <= M_RESP;
          st_addr <= rd_addr;
          st_data <= smem[rd_addr[7:0]];
          ms      <= 2;
        end
        default: if (mem_msg_out == M_NO) ms <= 0;
      endcase
    end
  end

  // ---------------- request monitor: each new request after NO_REQ -------
  logic [AW-1:0] iss_addr [$];
  logic [MB-1:0] iss_msg [$];
  logic [MB-1:0] prev_msg = '0;

  always @(negedge clock) begin
    if (mem_msg_out != M_NO && prev_msg == M_NO) begin
      iss_addr.push_back(mem_address_out);
      iss_msg.push_back(mem_msg_out);
    end
    prev_msg <= mem_msg_out;
  end

  // ---------------- reference memory at transaction level -----------------
  logic [31:0] ref_mem [0:255];

  task automatic ref_reload();
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
  endtask

  function automatic logic [LW-1:0] ref_line(input logic [AW-1:0] base);
    logic [LW-1:0] l;
    for (int i = 0; i < WPL; i++) l[i*DW +: DW] = ref_mem[(int'(base) + i) % 256];
    return l;
  endfunction

  task automatic ref_write(input logic [AW-1:0] base, input logic [LW-1:0] d);
    for (int i = 0; i < WPL; i++) ref_mem[(int'(base) + i) % 256] = d[i*DW +: DW];
  endtask

  // ---------------- checking helpers --------------------------------------
  int   n_vec = 0;
  int   n_bad = 0;
  logic ready_seen = 1'b0;

  task automatic chk(input string nm, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic start_req(input logic wr, input logic [AW-1:0] a, input logic [LW-1:0] d);
    @(negedge clock);
    req_valid   = 1'b1;
    req_write   = wr;
    req_address = a;
    req_data    = d;
  endtask

  // Cycles from the accept edge until resp_valid is seen; -1 if it never comes.
  task automatic wait_resp(input int spur_cycle, output int lat);
    for (int c = 1; c <= 200; c++) begin
      @(posedge clock);
      @(negedge clock);
      if (resp_valid) begin
        spur = 1'b0;
        lat  = c;
        return;
      end
      if (req_ready) ready_seen = 1'b1;
      spur = (c == spur_cycle);
    end
    spur = 1'b0;
    lat  = -1;
    n_vec++;
    n_bad++;
    $display("FAIL resp_wait: no resp_valid within 200 cycles");
  endtask

  task automatic run_line(input string tag, input logic wr, input logic [AW-1:0] a,
                          input logic [LW-1:0] d, input int exp_lat,
                          input logic [LW-1:0] exp_rdata, input logic [AW-1:0] exp_base);
    int s;
    int l;
    s = iss_addr.size();
    start_req(wr, a, d);
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    wait_resp(-1, l);
    chk({tag, " latency"}, LW'(l), LW'(exp_lat));
    if (l > 0) begin
      if (!wr) chk({tag, " resp_data"}, resp_data, exp_rdata);
      chk({tag, " error"}, LW'(error), '0);
      chk({tag, " done_msg"}, LW'(mem_msg_out), LW'(M_NO));
    end
    chk({tag, " req_count"}, LW'(iss_addr.size() - s), LW'(WPL));
    for (int i = 0; i < WPL; i++) begin
      if (s + i < iss_addr.size()) begin
        chk({tag, $sformatf(" addr%0d", i)}, LW'(iss_addr[s+i]), LW'(exp_base + AW'(i)));
        chk({tag, $sformatf(" msg%0d", i)}, LW'(iss_msg[s+i]), LW'(wr ? M_WB : M_RD));
      end
    end
  endtask

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [LW-1:0] wdata;
    int            exp_lat;
    logic [LW-1:0] exp_rdata;
    logic [AW-1:0] exp_base;
  } vec_t;

  localparam logic [LW-1:0] LINE_D  = 128'hD3D3_0003_D2D2_0002_D1D1_0001_D0D0_0000;
  localparam logic [LW-1:0] LINE_A  = 128'hA000_0003_A000_0002_A000_0001_A000_0000;
  localparam logic [LW-1:0] LINE_A4 = 128'hA000_0007_A000_0006_A000_0005_A000_0004;
  localparam logic [LW-1:0] LINE_B  = 128'hBEEF_0003_BEEF_0002_BEEF_0001_BEEF_0000;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [4];
    int   l;
    int   s;
    logic wr;
    logic [AW-1:0] a;
    logic [AW-1:0] base;
    logic [LW-1:0] d;

    tbl[0] = '{1'b1, 32'h80, LINE_D, WB_LAT, '0,      32'h80};
    tbl[1] = '{1'b0, 32'h80, '0,     RD_LAT, LINE_D,  32'h80};
    tbl[2] = '{1'b0, 32'h40, '0,     RD_LAT, LINE_A,  32'h40};
    tbl[3] = '{1'b0, 32'h47, '0,     RD_LAT, LINE_A4, 32'h44};
    ref_reload();

    // Reset values while reset is held low.
    repeat (2) @(negedge clock);
    chk("rst resp_valid", LW'(resp_valid), '0);
    chk("rst error", LW'(error), '0);
    chk("rst resp_data", resp_data, '0);
    chk("rst msg", LW'(mem_msg_out), LW'(M_NO));
    chk("rst addr", LW'(mem_address_out), '0);
    chk("rst wdata", LW'(mem_data_out), '0);
    reset = 1'b1;
    @(negedge clock);
    chk("rst req_ready", LW'(req_ready), LW'(1));

    // Table vectors: writeback/readback, preloaded read, unaligned base.
    for (int k = 0; k < 4; k++) begin
      run_line($sformatf("vec%0d", k), tbl[k].wr, tbl[k].addr, tbl[k].wdata,
               tbl[k].exp_lat, tbl[k].exp_rdata, tbl[k].exp_base);
      if (tbl[k].wr) ref_write(tbl[k].exp_base, tbl[k].wdata);
    end

    // req_valid held through a busy line; second line waits for DONE.
    ready_seen = 1'b0;
    s = iss_addr.size();
    start_req(1'b0, 32'h40, '0);
    @(posedge clock);
    @(negedge clock);
    req_write   = 1'b1;
    req_address = 32'hC0;
    req_data    = LINE_B;
    wait_resp(-1, l);
    chk("held latency", LW'(l), LW'(RD_LAT));
    chk("held ready_low_busy", LW'(ready_seen), '0);
    chk("held resp_data", resp_data, LINE_A);
    chk("held first_line_reqs", LW'(iss_addr.size() - s), LW'(WPL));
    @(posedge clock);
    @(negedge clock);
    chk("held ready_after_done", LW'(req_ready), LW'(1));
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    chk("held second_msg", LW'(mem_msg_out), LW'(M_WB));
    chk("held second_addr", LW'(mem_address_out), LW'(32'hC0));
    wait_resp(-1, l);
    chk("held second_latency", LW'(l), LW'(WB_LAT));
    ref_write(32'hC0, LINE_B);
    run_line("held readback", 1'b0, 32'hC0, '0, RD_LAT, LINE_B, 32'hC0);

    // Reset asserted during word 2 of a read.
    s = iss_addr.size();
    start_req(1'b0, 32'h20, '0);
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clock);
      #1;
      if (iss_addr.size() - s >= 3) break;
    end
    chk("midrst word2_reached", LW'(iss_addr.size() - s), LW'(3));
    reset = 1'b0;
    #1;
    chk("midrst resp_valid", LW'(resp_valid), '0);
    chk("midrst error", LW'(error), '0);
    chk("midrst resp_data", resp_data, '0);
    chk("midrst msg", LW'(mem_msg_out), LW'(M_NO));
    chk("midrst addr", LW'(mem_address_out), '0);
    chk("midrst wdata", LW'(mem_data_out), '0);
    @(negedge clock);
    reset = 1'b1;
    ref_reload();
    @(negedge clock);
    chk("midrst req_ready", LW'(req_ready), LW'(1));
    run_line("midrst clean", 1'b0, 32'h20, '0, RD_LAT, ref_line(32'h20), 32'h20);

`ifdef MEM_REQ_TIMEOUT_EN
    // Memory never replies; a spurious reply with a foreign address is ignored.
    mute = 1'b1;
    start_req(1'b0, 32'h30, '0);
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    wait_resp(3, l);
    chk("timeout latency", LW'(l), LW'(TO));
    chk("timeout error", LW'(error), LW'(1));
    chk("timeout msg", LW'(mem_msg_out), LW'(M_NO));
    @(posedge clock);
    @(negedge clock);
    chk("timeout error_held", LW'(error), LW'(1));
    mute = 1'b0;
    run_line("timeout recover", 1'b0, 32'h30, '0, RD_LAT, ref_line(32'h30), 32'h30);
`endif

    // Random lines against the transaction-level reference memory.
    for (int k = 0; k < 24; k++) begin
      wr   = 1'($urandom_range(0, 1));
      a    = AW'($urandom_range(0, 250));
      base = a & ~AW'(WPL - 1);
      d    = {$urandom(), $urandom(), $urandom(), $urandom()};
      run_line($sformatf("rnd%0d", k), wr, a, d, wr ? WB_LAT : RD_LAT,
               ref_line(base), base);
      if (wr) ref_write(base, d);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
